// File: rtl/lc_pkg.sv
// Shared types and sizing helpers for the truth-table sweep engine.
package lc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lc_state_t;

  // hold counter width; a single-cycle hold still needs one bit
  function automatic int hold_w(input int hold_cycles);
    return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/lc_tt_reg.sv
// Truth-table register with reset preload, gated write, a registered eval
// read port and a combinational compare read port.
module lc_tt_reg
  import lc_pkg::*;
#(
  parameter int                      N_IN    = 4,
  parameter int                      TT_W    = 1 << N_IN,
  parameter logic [(1<<N_IN)-1:0]    TT_INIT = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [TT_W-1:0] wdata,
  input  logic [N_IN-1:0] eval_addr,
  output logic            eval_q,
  input  logic [N_IN-1:0] cmp_addr,
  output logic            cmp_bit
);

  logic [TT_W-1:0] tt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt     <= TT_INIT;
      eval_q <= 1'b0;
    end else begin
      if (we) tt <= wdata;
      eval_q <= tt[eval_addr];
    end
  end

  assign cmp_bit = tt[cmp_addr];

endmodule

// File: rtl/lc_sweep_engine.sv
// Programmable N-input logic cell with an exhaustive sweep checker that
// drives every input vector to an external circuit and tallies mismatches.
module lc_sweep_engine
  import lc_pkg::*;
#(
  parameter int                   N_IN        = 4,
  parameter int                   HOLD_CYCLES = 1,
  parameter logic [(1<<N_IN)-1:0] TT_INIT     = 16'h70FF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [(1<<N_IN)-1:0]   cfg_tt,
  input  logic [N_IN-1:0]        in_vec,
  output logic                   eval_out,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN:0]          mismatch_cnt,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail
);

  localparam int HW = hold_w(HOLD_CYCLES);
  localparam int CW = N_IN + 1;
  localparam logic [N_IN-1:0] VEC_MAX  = '1;
  localparam logic [HW-1:0]   HOLD_END = HW'(HOLD_CYCLES - 1);

  lc_state_t     state, state_n;
  logic [HW-1:0] hold_cnt;
  logic          exp_bit;
  logic          last_hold;
  logic          tt_we;

  // table is frozen outside IDLE so a sweep checks against a stable reference
  assign tt_we     = cfg_we && (state == IDLE);
  assign last_hold = (hold_cnt == HOLD_END);

  lc_tt_reg #(
    .N_IN    (N_IN),
    .TT_INIT (TT_INIT)
  ) u_tt (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (tt_we),
    .wdata     (cfg_tt),
    .eval_addr (in_vec),
    .eval_q    (eval_out),
    .cmp_addr  (vec_out),
    .cmp_bit   (exp_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_hold && (vec_out == VEC_MAX)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_out      <= '0;
      hold_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      first_fail   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec_out      <= '0;
            hold_cnt     <= '0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          if (!last_hold) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            if (dut_out != exp_bit) begin
              mismatch_cnt <= mismatch_cnt + CW'(1);
              if (!fail_valid) begin
                first_fail <= vec_out;
                fail_valid <= 1'b1;
              end
            end
            if (vec_out == VEC_MAX) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              vec_out <= '0;
            end else begin
              vec_out  <= vec_out + N_IN'(1);
              hold_cnt <= '0;
            end
          end
        end
        DONE:    done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule
